// File: rtl/inst_queue_pkg.sv
// Shared IQ entry layout: field widths and the packed 97-bit entry carried from fetcher to dispatcher.
package inst_queue_pkg;

    localparam int INST_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    // Bit offsets inside the packed entry, LSB first.
    localparam int IQ_JUMP_OFF   = 0;
    localparam int IQ_RBPC_OFF   = IQ_JUMP_OFF + 1;
    localparam int IQ_PC_OFF     = IQ_RBPC_OFF + ADDR_WIDTH;
    localparam int IQ_INST_OFF   = IQ_PC_OFF + ADDR_WIDTH;
    localparam int IQ_ENTRY_BITS = IQ_INST_OFF + INST_WIDTH;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] rollback_pc;
        logic                  predicted_jump;
    } iq_entry_t;

endpackage

// File: rtl/iq_entry_ram.sv
// IQ entry storage: DEPTH x 97 array, one synchronous write port, one asynchronous read port.
// Latency: write visible on read port after the write edge; read is combinational.
// Backpressure: none; the owner gates the write enable.
module iq_entry_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  iq_entry_t             wr_dat,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output iq_entry_t             rd_dat
);

    iq_entry_t mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-dispatch instruction FIFO, flushed on RoB rollback; IQ_BYPASS_EN enables the empty-queue bypass.
// Latency: 2 edges push-to-issue through the array, 1 edge when bypassing an empty queue.
// Backpressure: iq_full_out at DEPTH-1 entries; issue waits for ready_from_dispatcher; rdy_in low freezes all.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  ok_flag_from_fetcher,
    input  logic [INST_WIDTH-1:0] inst_from_fetcher,
    input  logic [ADDR_WIDTH-1:0] pc_from_fetcher,
    input  logic [ADDR_WIDTH-1:0] rollback_pc_from_fetcher,
    input  logic                  predicted_jump_from_fetcher,
    output logic                  iq_full_out,
    input  logic                  ready_from_dispatcher,
    output logic                  ok_flag_to_dispatcher,
    output logic [INST_WIDTH-1:0] inst_to_decoder,
    output logic [ADDR_WIDTH-1:0] pc_to_dispatcher,
    output logic [ADDR_WIDTH-1:0] rollback_pc_to_dispatcher,
    output logic                  predicted_jump_to_dispatcher,
    input  logic                  rollback_flag_from_RoB
);

    localparam logic [DEPTH_LOG2:0] CNT_MAX   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] FULL_MARK = (DEPTH_LOG2+1)'(DEPTH - 1);

    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [DEPTH_LOG2:0]   count;

    iq_entry_t wr_entry;
    iq_entry_t rd_entry;
    logic      do_pop;
    logic      do_push;
    logic      bypass;
    logic      overflow;
    logic      ram_wr_en;

    assign wr_entry = '{inst:           inst_from_fetcher,
                        pc:             pc_from_fetcher,
                        rollback_pc:    rollback_pc_from_fetcher,
                        predicted_jump: predicted_jump_from_fetcher};

    assign do_pop = (count != '0) && ready_from_dispatcher;

`ifdef IQ_BYPASS_EN
    assign bypass = (count == '0) && ok_flag_from_fetcher && ready_from_dispatcher;
`else
    assign bypass = 1'b0;
`endif

    // A pop in the same edge frees the slot, so push+pop at DEPTH is legal.
    assign overflow    = ok_flag_from_fetcher && (count == CNT_MAX) && !do_pop;
    assign do_push     = ok_flag_from_fetcher && !bypass && !overflow;
    assign iq_full_out = (count >= FULL_MARK);
    assign ram_wr_en   = rdy_in && !rollback_flag_from_RoB && do_push;

    iq_entry_ram #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_in  (clk_in),
        .wr_en   (ram_wr_en),
        .wr_addr (tail),
        .wr_dat  (wr_entry),
        .rd_addr (head),
        .rd_dat  (rd_entry)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head                         <= '0;
            tail                         <= '0;
            count                        <= '0;
            ok_flag_to_dispatcher        <= 1'b0;
            inst_to_decoder              <= '0;
            pc_to_dispatcher             <= '0;
            rollback_pc_to_dispatcher    <= '0;
            predicted_jump_to_dispatcher <= 1'b0;
        end else if (rdy_in) begin
            if (rollback_flag_from_RoB) begin
                // Anything fetched alongside the flush is on the wrong path.
                head                  <= '0;
                tail                  <= '0;
                count                 <= '0;
                ok_flag_to_dispatcher <= 1'b0;
            end else begin
                if (do_push) begin
                    tail <= tail + 1'b1;
                end
                if (do_pop) begin
                    head                         <= head + 1'b1;
                    ok_flag_to_dispatcher        <= 1'b1;
                    inst_to_decoder              <= rd_entry.inst;
                    pc_to_dispatcher             <= rd_entry.pc;
                    rollback_pc_to_dispatcher    <= rd_entry.rollback_pc;
                    predicted_jump_to_dispatcher <= rd_entry.predicted_jump;
                end else if (bypass) begin
                    ok_flag_to_dispatcher        <= 1'b1;
                    inst_to_decoder              <= inst_from_fetcher;
                    pc_to_dispatcher             <= pc_from_fetcher;
                    rollback_pc_to_dispatcher    <= rollback_pc_from_fetcher;
                    predicted_jump_to_dispatcher <= predicted_jump_from_fetcher;
                end else begin
                    ok_flag_to_dispatcher <= 1'b0;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always @(posedge clk_in) begin
        if (rst_in && rdy_in && !rollback_flag_from_RoB) begin
            assert (!overflow) else $error("inst_queue: push into full queue discarded");
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a pc-keyed scoreboard checked on every issued entry.
module tb_inst_queue;

    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        ok_flag_from_fetcher;
    logic [31:0] inst_from_fetcher;
    logic [31:0] pc_from_fetcher;
    logic [31:0] rollback_pc_from_fetcher;
    logic        predicted_jump_from_fetcher;
    logic        iq_full_out;
    logic        ready_from_dispatcher;
    logic        ok_flag_to_dispatcher;
    logic [31:0] inst_to_decoder;
    logic [31:0] pc_to_dispatcher;
    logic [31:0] rollback_pc_to_dispatcher;
    logic        predicted_jump_to_dispatcher;
    logic        rollback_flag_from_RoB;

    int n_checks = 0;
    int n_fail   = 0;
    int mc       = 0;
    logic [31:0] q[$];
    logic        last_rdy = 1'b0;
    logic [31:0] e;

    inst_queue #(.DEPTH(DEPTH), .DEPTH_LOG2(4)) dut (
        .clk_in                       (clk_in),
        .rst_in                       (rst_in),
        .rdy_in                       (rdy_in),
        .ok_flag_from_fetcher         (ok_flag_from_fetcher),
        .inst_from_fetcher            (inst_from_fetcher),
        .pc_from_fetcher              (pc_from_fetcher),
        .rollback_pc_from_fetcher     (rollback_pc_from_fetcher),
        .predicted_jump_from_fetcher  (predicted_jump_from_fetcher),
        .iq_full_out                  (iq_full_out),
        .ready_from_dispatcher        (ready_from_dispatcher),
        .ok_flag_to_dispatcher        (ok_flag_to_dispatcher),
        .inst_to_decoder              (inst_to_decoder),
        .pc_to_dispatcher             (pc_to_dispatcher),
        .rollback_pc_to_dispatcher    (rollback_pc_to_dispatcher),
        .predicted_jump_to_dispatcher (predicted_jump_to_dispatcher),
        .rollback_flag_from_RoB       (rollback_flag_from_RoB)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update the reference model.
    task automatic cyc(input logic push, input logic [31:0] pc, input logic ready,
                       input logic rb, input logic rdy);
        logic pop;
        logic bp;
        ok_flag_from_fetcher        = push;
        pc_from_fetcher             = pc;
        inst_from_fetcher           = mk_inst(pc);
        rollback_pc_from_fetcher    = pc + 32'd4;
        predicted_jump_from_fetcher = pc[2];
        ready_from_dispatcher       = ready;
        rollback_flag_from_RoB      = rb;
        rdy_in                      = rdy;
        @(posedge clk_in);
        #1;
        if (rdy) begin
            if (rb) begin
                q.delete();
                mc = 0;
            end else begin
                bp = 1'b0;
`ifdef IQ_BYPASS_EN
                bp = push && ready && (mc == 0);
`endif
                pop = (mc != 0) && ready;
                if (bp) begin
                    q.push_back(pc);
                end else begin
                    if (push && (mc < DEPTH || pop)) begin
                        q.push_back(pc);
                        mc++;
                    end
                    if (pop) mc--;
                end
            end
        end
    endtask

    always @(posedge clk_in) last_rdy <= rdy_in;

    // Scoreboard: every fresh issue pulse must match the oldest accepted push.
    always @(negedge clk_in) begin
        if (rst_in && last_rdy && ok_flag_to_dispatcher) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", 32'(ok_flag_to_dispatcher), 32'd0);
            end else begin
                e = q.pop_front();
                check("sb_pc", pc_to_dispatcher, e);
                check("sb_rollback_pc", rollback_pc_to_dispatcher, e + 32'd4);
                check("sb_inst", inst_to_decoder, mk_inst(e));
                check("sb_jump", 32'(predicted_jump_to_dispatcher), 32'(e[2]));
            end
        end
    end

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        ok_flag_from_fetcher = 1'b0;
        inst_from_fetcher = '0;
        pc_from_fetcher = '0;
        rollback_pc_from_fetcher = '0;
        predicted_jump_from_fetcher = 1'b0;
        ready_from_dispatcher = 1'b0;
        rollback_flag_from_RoB = 1'b0;
        #12;
        check("rst_ok", 32'(ok_flag_to_dispatcher), 32'd0);
        check("rst_pc", pc_to_dispatcher, 32'd0);
        check("rst_full", 32'(iq_full_out), 32'd0);
        check("rst_count", 32'(dut.count), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Three entries held back, then issued back to back.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b1);
        check("t2_count3", 32'(dut.count), 32'd3);
        check("t2_no_pulse", 32'(ok_flag_to_dispatcher), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
            check("t2_ok", 32'(ok_flag_to_dispatcher), 32'd1);
            check("t2_pc", pc_to_dispatcher, 32'(i * 4));
            check("t2_rbpc", rollback_pc_to_dispatcher, 32'(i * 4 + 4));
        end
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        check("t2_drained", 32'(dut.count), 32'd0);
        check("t2_ok_low", 32'(ok_flag_to_dispatcher), 32'd0);

        // Fill to DEPTH, push+pop at DEPTH, drain through pointer wrap.
        for (int i = 0; i < 14; i++) cyc(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
        check("t3_full_14", 32'(iq_full_out), 32'd0);
        cyc(1'b1, 32'h1000 + 32'(14 * 4), 1'b0, 1'b0, 1'b1);
        check("t3_full_15", 32'(iq_full_out), 32'd1);
        cyc(1'b1, 32'h1000 + 32'(15 * 4), 1'b0, 1'b0, 1'b1);
        check("t3_count16", 32'(dut.count), 32'd16);
        check("t3_full_16", 32'(iq_full_out), 32'd1);
        for (int i = 16; i < 19; i++) begin
            cyc(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 1'b0, 1'b1);
            check("t3_pushpop_count", 32'(dut.count), 32'd16);
        end
        for (int i = 0; i < 16; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("t3_drained", 32'(dut.count), 32'd0);
        check("t3_full_low", 32'(iq_full_out), 32'd0);
        check("t3_sb_empty", 32'(q.size()), 32'd0);

        // Rollback at count 7 with a concurrent push.
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'h2000 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h2000 + 32'(7 * 4), 1'b1, 1'b0, 1'b1);
        check("t4_count7", 32'(dut.count), 32'd7);
        check("t4_ok_before", 32'(ok_flag_to_dispatcher), 32'd1);
        cyc(1'b1, 32'h000D_EAD0, 1'b1, 1'b1, 1'b1);
        check("t4_rb_count", 32'(dut.count), 32'd0);
        check("t4_rb_ok", 32'(ok_flag_to_dispatcher), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        check("t4_still_empty", 32'(dut.count), 32'd0);

        // rdy_in low mid-stream freezes everything.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h4000 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h0000_BAD0, 1'b1, 1'b0, 1'b0);
            check("t5_frz_count", 32'(dut.count), 32'd3);
            check("t5_frz_pc", pc_to_dispatcher, 32'h4000);
            check("t5_frz_ok", 32'(ok_flag_to_dispatcher), 32'd1);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        check("t5_drained", 32'(dut.count), 32'd0);
        check("t5_sb_empty", 32'(q.size()), 32'd0);

        // Asynchronous reset with traffic in flight.
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        check("t1_count5", 32'(dut.count), 32'd5);
        ready_from_dispatcher = 1'b0;
        rst_in = 1'b0;
        #1;
        check("t1_ok", 32'(ok_flag_to_dispatcher), 32'd0);
        check("t1_count", 32'(dut.count), 32'd0);
        check("t1_pc", pc_to_dispatcher, 32'd0);
        check("t1_rbpc", rollback_pc_to_dispatcher, 32'd0);
        q.delete();
        mc = 0;
        @(negedge clk_in);
        rst_in = 1'b1;

        // Empty-queue push with dispatcher ready.
        cyc(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
`ifdef IQ_BYPASS_EN
        check("t6_ok", 32'(ok_flag_to_dispatcher), 32'd1);
        check("t6_pc", pc_to_dispatcher, 32'h100);
        check("t6_count", 32'(dut.count), 32'd0);
`else
        check("t6_ok_early", 32'(ok_flag_to_dispatcher), 32'd0);
        check("t6_count", 32'(dut.count), 32'd1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        check("t6_ok", 32'(ok_flag_to_dispatcher), 32'd1);
        check("t6_pc", pc_to_dispatcher, 32'h100);
`endif
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        check("end_count", 32'(dut.count), 32'd0);
        check("end_sb_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
